// File: rtl/wdf_output_capture.sv
// wdf_output_capture
//   Captures a fixed-length run of TOTAL_SAMPLES signed samples from the WDF
//   core into a small first-word-fall-through FIFO for a ready/valid
//   consumer. It also keeps running statistics (count, peak magnitude,
//   checksum) and raises a sticky done flag when the run has drained.
//
// Ports
//   clk           single clock for all logic
//   reset         synchronous, active-high; clears all state
//   start         one-cycle pulse; begins a run from IDLE or DONE
//   sample_valid  WDF output sample present this cycle
//   sample_data   signed WDF output sample
//   out_valid     FIFO head valid
//   out_data      FIFO head sample (zero when empty)
//   out_ready     consumer accepts head
//   busy          run in progress (CAPTURE or DRAIN)
//   done          run complete; held until next start or reset
//   overflow      sticky: at least one sample dropped this run
//   sample_count  samples observed this run
//   peak_abs      unsigned max |sample| this run
//   checksum      wrap-around sum of sign-extended samples
module wdf_output_capture #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned TOTAL_SAMPLES = 1024,
  parameter int unsigned FIFO_DEPTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [31:0]           sample_count,
  output logic [DATA_WIDTH-1:0] peak_abs,
  output logic [31:0]           checksum
);

  localparam int unsigned      PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned      CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]      LAST_IDX = 32'(TOTAL_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN,
    DONE
  } state_t;

  state_t state, next_state;

  logic                  clear;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;

  logic signed [DATA_WIDTH-1:0] sample_s;
  logic [31:0]                  sample_ext;
  logic [DATA_WIDTH-1:0]        sample_mag;

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    clear      = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear      = 1'b1;
          next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        if (sample_valid) begin
          accept = 1'b1;
          if (sample_count == LAST_IDX) begin
            next_state = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Uses the registered occupancy, so the final pop lands one edge
        // before DONE is entered.
        if (fifo_empty) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (start) begin
          clear      = 1'b1;
          next_state = CAPTURE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == CAPTURE) || (state == DRAIN);
  assign done = (state == DONE);

  // ---------------------------------------------------------------------
  // FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == DEPTH_C);
  assign out_valid  = !fifo_empty;
  assign out_data   = out_valid ? mem[rd_ptr] : '0;

  assign pop  = out_valid && out_ready;
  // A full FIFO still takes the sample when the head leaves in the same cycle.
  assign push = accept && (!fifo_full || pop);
  assign drop = accept && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= sample_data;
    end
  end

  // ---------------------------------------------------------------------
  // Running statistics
  // ---------------------------------------------------------------------
  assign sample_s   = sample_data;
  assign sample_ext = 32'(sample_s);
  // Two's-complement negation in DATA_WIDTH bits; the most-negative value
  // maps to 2^(DATA_WIDTH-1), which is exact when read as unsigned.
  assign sample_mag = sample_data[DATA_WIDTH-1] ? (~sample_data + DATA_WIDTH'(1))
                                                : sample_data;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sample_count <= '0;
      checksum     <= '0;
      peak_abs     <= '0;
      overflow     <= 1'b0;
    end else if (accept) begin
      sample_count <= sample_count + 32'd1;
      checksum     <= checksum + sample_ext;
      if (sample_mag > peak_abs) begin
        peak_abs <= sample_mag;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wdf_output_capture.sv
// Testbench for wdf_output_capture (DATA_WIDTH=16, TOTAL_SAMPLES=8,
// FIFO_DEPTH=4). Expected FIFO output is pushed to a queue by the stimulus
// driver and popped by a monitor whenever the consumer takes the head.
module tb_wdf_output_capture;

  localparam int unsigned DW  = 16;
  localparam int unsigned TOT = 8;
  localparam int unsigned DEP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          sample_valid;
  logic [DW-1:0] sample_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [31:0]   sample_count;
  logic [DW-1:0] peak_abs;
  logic [31:0]   checksum;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;
  logic [31:0]   exp_cnt;
  logic [31:0]   exp_sum;
  logic [DW-1:0] exp_peak;
  logic          exp_ovf;
  bit            m_cap;

  wdf_output_capture #(
    .DATA_WIDTH(DW),
    .TOTAL_SAMPLES(TOT),
    .FIFO_DEPTH(DEP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .sample_valid(sample_valid),
    .sample_data(sample_data),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .busy(busy),
    .done(done),
    .overflow(overflow),
    .sample_count(sample_count),
    .peak_abs(peak_abs),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  // Scoreboard: every head transfer must match the oldest expected sample.
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected: out_data=%0d, no sample expected", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          failures++;
          $display("FAIL out_data: got %0d want %0d", out_data, mon_exp);
        end
      end
    end
  end

  // One cycle of stimulus; the reference model decides acceptance from its
  // own occupancy and the consumer's ready.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic s);
    logic [DW-1:0] mag;
    bit            pop_now;
    sample_valid = v;
    sample_data  = d;
    out_ready    = r;
    start        = s;
    pop_now      = (exp_q.size() > 0) && r;
    if (m_cap && v) begin
      if (exp_q.size() < DEP || pop_now) exp_q.push_back(d);
      else exp_ovf = 1'b1;
      exp_cnt = exp_cnt + 32'd1;
      exp_sum = exp_sum + {{(32-DW){d[DW-1]}}, d};
      mag = d[DW-1] ? (~d + 16'd1) : d;
      if (mag > exp_peak) exp_peak = mag;
      if (exp_cnt == TOT) m_cap = 1'b0;
    end
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    start        = 1'b0;
  endtask

  task automatic pulse_start();
    exp_q.delete();
    exp_cnt  = '0;
    exp_sum  = '0;
    exp_peak = '0;
    exp_ovf  = 1'b0;
    m_cap    = 1'b1;
    sample_valid = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget, input logic r);
    for (int unsigned n = 0; n < budget && done !== 1'b1; n++) drive(1'b0, '0, r, 1'b0);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL wait_done: done=%b after %0d cycles, want 1", done, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL rst_out_data: got %0d want 0", out_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    checks++; if (sample_count !== 32'd0) begin failures++; $display("FAIL rst_count: got %0d want 0", sample_count); end
    checks++; if (peak_abs !== '0) begin failures++; $display("FAIL rst_peak: got %0d want 0", peak_abs); end
    checks++; if (checksum !== 32'd0) begin failures++; $display("FAIL rst_checksum: got %h want 0", checksum); end
    reset = 1'b0;
    // Samples in IDLE are ignored.
    drive(1'b1, 16'd99, 1'b1, 1'b0);
    checks++; if (sample_count !== 32'd0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL idle_ignore: count=%0d out_valid=%b want 0/0", sample_count, out_valid);
    end
  endtask

  task automatic test_basic();
    pulse_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_rise: got %b want 1", busy); end
    for (int i = 1; i <= 8; i++) drive(1'b1, 16'(i), 1'b1, 1'b0);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL basic_last+1: busy=%b done=%b want 1/0", busy, done); end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_last+2: done=%b want 0", done); end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL basic_done_timing: busy=%b done=%b want 0/1", busy, done); end
    checks++; if (sample_count !== 32'd8) begin failures++; $display("FAIL basic_count: got %0d want 8", sample_count); end
    checks++; if (checksum !== 32'd36) begin failures++; $display("FAIL basic_checksum: got %0d want 36", checksum); end
    checks++; if (peak_abs !== 16'd8) begin failures++; $display("FAIL basic_peak: got %0d want 8", peak_abs); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL basic_overflow: got %b want 0", overflow); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL basic_drained: %0d samples never output, want 0", exp_q.size()); end
    // Statistics are frozen in DONE.
    drive(1'b1, 16'd7, 1'b1, 1'b0);
    checks++; if (sample_count !== 32'd8 || out_valid !== 1'b0) begin
      failures++; $display("FAIL done_frozen: count=%0d out_valid=%b want 8/0", sample_count, out_valid);
    end
  endtask

  task automatic test_sign();
    pulse_start();
    drive(1'b1, 16'h8000, 1'b1, 1'b0);
    drive(1'b1, 16'd5,    1'b1, 1'b0);
    drive(1'b1, 16'hFFFD, 1'b1, 1'b0);
    checks++; if (peak_abs !== 16'h8000) begin failures++; $display("FAIL sign_peak: got %0d want 32768", peak_abs); end
    checks++; if (checksum !== 32'hFFFF8002) begin failures++; $display("FAIL sign_checksum: got %h want ffff8002", checksum); end
    for (int i = 0; i < 5; i++) drive(1'b1, '0, 1'b1, 1'b0);
    wait_done(10, 1'b1);
    checks++; if (checksum !== exp_sum || peak_abs !== exp_peak) begin
      failures++; $display("FAIL sign_final: checksum=%h peak=%0d want %h/%0d", checksum, peak_abs, exp_sum, exp_peak);
    end
  endtask

  task automatic test_backpressure();
    pulse_start();
    for (int i = 0; i < 4; i++) drive(1'b1, 16'(10 + i), 1'b0, 1'b0);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL bp_ovf_early: got %b want 0", overflow); end
    drive(1'b1, 16'd14, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL bp_ovf_set: got %b want 1", overflow); end
    for (int i = 15; i <= 17; i++) drive(1'b1, 16'(i), 1'b0, 1'b0);
    checks++; if (sample_count !== exp_cnt) begin failures++; $display("FAIL bp_count: got %0d want %0d", sample_count, exp_cnt); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'd10) begin
        failures++;
        $display("FAIL bp_hold: busy=%b done=%b out_valid=%b out_data=%0d want 1/0/1/10", busy, done, out_valid, out_data);
      end
    end
    wait_done(12, 1'b1);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_drained: %0d samples never output, want 0", exp_q.size()); end
    checks++; if (overflow !== exp_ovf || sample_count !== 32'd8) begin
      failures++; $display("FAIL bp_final: overflow=%b count=%0d want %b/8", overflow, sample_count, exp_ovf);
    end
  endtask

  task automatic test_start_done();
    pulse_start();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || sample_count !== 32'd0 || checksum !== 32'd0 ||
        peak_abs !== '0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL restart_clear: done=%b busy=%b count=%0d sum=%h peak=%0d ovf=%b want 0/1/0/0/0/0",
               done, busy, sample_count, checksum, peak_abs, overflow);
    end
    for (int i = 0; i < 8; i++) drive(1'b1, 16'(100 - 30 * i), 1'b1, 1'b0);
    wait_done(10, 1'b1);
    checks++;
    if (sample_count !== exp_cnt || checksum !== exp_sum || peak_abs !== exp_peak) begin
      failures++;
      $display("FAIL restart_stats: count=%0d sum=%h peak=%0d want %0d/%h/%0d",
               sample_count, checksum, peak_abs, exp_cnt, exp_sum, exp_peak);
    end
  endtask

  task automatic test_full_pop();
    pulse_start();
    for (int i = 0; i < 4; i++) drive(1'b1, 16'(20 + i), 1'b0, 1'b0);
    drive(1'b1, 16'd24, 1'b1, 1'b0);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fullpop_ovf: got %b want 0", overflow); end
    checks++; if (sample_count !== 32'd5) begin failures++; $display("FAIL fullpop_count: got %0d want 5", sample_count); end
    for (int i = 25; i <= 27; i++) drive(1'b1, 16'(i), 1'b1, 1'b0);
    wait_done(12, 1'b1);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fullpop_ovf_final: got %b want 0", overflow); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL fullpop_drained: %0d samples never output, want 0", exp_q.size()); end
  endtask

  task automatic test_start_busy();
    pulse_start();
    for (int i = 0; i < 3; i++) drive(1'b1, 16'(50 + i), 1'b1, 1'b0);
    drive(1'b1, 16'd53, 1'b1, 1'b1);
    checks++; if (sample_count !== 32'd4 || busy !== 1'b1) begin
      failures++; $display("FAIL start_busy_ignored: count=%0d busy=%b want 4/1", sample_count, busy);
    end
    for (int i = 4; i < 8; i++) drive(1'b1, 16'(50 + i), 1'b1, 1'b0);
    wait_done(10, 1'b1);
    checks++; if (sample_count !== 32'd8 || checksum !== exp_sum) begin
      failures++; $display("FAIL start_busy_final: count=%0d sum=%h want 8/%h", sample_count, checksum, exp_sum);
    end
  endtask

  task automatic test_reset_midrun();
    pulse_start();
    for (int i = 0; i < 3; i++) drive(1'b1, 16'(30 + i), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    out_ready    = 1'b0;
    reset        = 1'b1;
    sample_valid = 1'b1;
    sample_data  = 16'd33;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    sample_valid = 1'b0;
    exp_q.delete();
    m_cap = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || sample_count !== 32'd0 || busy !== 1'b0 || done !== 1'b0 ||
        checksum !== 32'd0 || peak_abs !== '0) begin
      failures++;
      $display("FAIL midrun_reset: out_valid=%b count=%0d busy=%b done=%b sum=%h peak=%0d want all 0",
               out_valid, sample_count, busy, done, checksum, peak_abs);
    end
    for (int i = 0; i < 3; i++) drive(1'b1, 16'(40 + i), 1'b1, 1'b0);
    checks++; if (sample_count !== 32'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL midrun_ignore: count=%0d out_valid=%b busy=%b want 0/0/0", sample_count, out_valid, busy);
    end
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    out_ready    = 1'b0;
    exp_cnt      = '0;
    exp_sum      = '0;
    exp_peak     = '0;
    exp_ovf      = 1'b0;
    m_cap        = 1'b0;
    test_reset();
    test_basic();
    test_sign();
    test_backpressure();
    test_start_done();
    test_full_pop();
    test_start_busy();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
